// File: rtl/arcade_trig_pkg.sv
// Arcade trigger generator shared types.
// Channel modes and channel FSM states.
package arcade_trig_pkg;

  typedef enum logic [1:0] {
    OFF     = 2'b00,
    ONESHOT = 2'b01,
    LEVEL   = 2'b10,
    REPEAT  = 2'b11
  } trig_mode_t;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACTIVE = 2'b01,
    GAP    = 2'b10
  } trig_state_t;

endpackage

// File: rtl/arcade_trigger_chan.sv
// One trigger channel: synchroniser, edge detect,
// pulse FSM and shared-length down-counter.
module arcade_trigger_chan
  import arcade_trig_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 20,
  parameter int unsigned SYNC_STG  = 2
) (
  input  logic                 clk_sys,
  input  logic                 reset_n,
  input  logic                 ce,
  input  logic                 trig_i,
  input  trig_mode_t           mode_i,
  input  logic [CNT_WIDTH-1:0] pulse_len,
  output logic                 pulse_o,
  output logic                 busy_o
);

  logic [SYNC_STG-1:0]  sync_q;
  logic [SYNC_STG-1:0]  vld_q;
  logic                 s_d_q;
  logic                 arm_q;
  logic                 arm_d;
  trig_mode_t           mode_q;
  trig_state_t          state_q;
  trig_state_t          state_d;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_d;
  logic                 pulse_q;
  logic                 pulse_d;
  logic                 busy_q;
  logic                 busy_d;

  logic                 s;
  logic                 rise;
  logic                 len_ok;
  logic                 cnt_zero;
  logic                 mode_chg;
  logic [CNT_WIDTH-1:0] load_val;

  // The synchroniser is cleared by reset, so a level
  // held across reset must be seen low once (with a
  // filled sync chain) before any rise is accepted.
  assign s        = sync_q[SYNC_STG-1];
  assign arm_d    = arm_q | (vld_q[SYNC_STG-1] & ~s);
  assign rise     = s & ~s_d_q & arm_q;
  assign len_ok   = |pulse_len;
  assign load_val = pulse_len - CNT_WIDTH'(1);
  assign cnt_zero = (cnt_q == '0);
  assign mode_chg = (mode_i != mode_q);

  // Next state, counter and output for this ce tick.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    if (mode_chg) begin
      state_d = IDLE;
    end else begin
      unique case (mode_q)
        OFF: begin
          state_d = IDLE;
        end
        LEVEL: begin
          state_d = IDLE;
          pulse_d = s;
        end
        ONESHOT: begin
          case (state_q)
            IDLE: begin
              if (rise && len_ok) begin
                state_d = ACTIVE;
                cnt_d   = load_val;
              end
            end
            ACTIVE: begin
              if (rise && len_ok) begin
                cnt_d = load_val;
              end else if (cnt_zero) begin
                state_d = IDLE;
              end else begin
                cnt_d = cnt_q - CNT_WIDTH'(1);
              end
            end
            default: state_d = IDLE;
          endcase
          pulse_d = (state_d == ACTIVE);
        end
        REPEAT: begin
          case (state_q)
            IDLE: begin
              if (rise && len_ok) begin
                state_d = ACTIVE;
                cnt_d   = load_val;
              end
            end
            ACTIVE: begin
              if (!cnt_zero) begin
                cnt_d = cnt_q - CNT_WIDTH'(1);
              end else if (len_ok) begin
                state_d = GAP;
                cnt_d   = load_val;
              end else begin
                state_d = IDLE;
              end
            end
            GAP: begin
              if (!cnt_zero) begin
                cnt_d = cnt_q - CNT_WIDTH'(1);
              end else if (s && len_ok) begin
                state_d = ACTIVE;
                cnt_d   = load_val;
              end else begin
                state_d = IDLE;
              end
            end
            default: state_d = IDLE;
          endcase
          pulse_d = (state_d == ACTIVE);
        end
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  // Channel registers, all advancing only on ce ticks.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= '0;
      vld_q   <= '0;
      s_d_q   <= 1'b0;
      arm_q   <= 1'b0;
      mode_q  <= OFF;
      state_q <= IDLE;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
      busy_q  <= 1'b0;
    end else if (ce) begin
      sync_q  <= {sync_q[SYNC_STG-2:0], trig_i};
      vld_q   <= {vld_q[SYNC_STG-2:0], 1'b1};
      s_d_q   <= s;
      arm_q   <= arm_d;
      mode_q  <= mode_i;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
      busy_q  <= busy_d;
    end
  end

  assign pulse_o = pulse_q;
  assign busy_o  = busy_q;

endmodule

// File: rtl/arcade_trigger_gen.sv
// Multi-channel arcade trigger/pulse generator.
// One channel instance per trigger, busy ORed.
module arcade_trigger_gen
  import arcade_trig_pkg::*;
#(
  parameter int unsigned CHANNELS  = 4,
  parameter int unsigned CNT_WIDTH = 20,
  parameter int unsigned SYNC_STG  = 2
) (
  input  logic                  clk_sys,
  input  logic                  reset_n,
  input  logic                  ce,
  input  logic [CHANNELS-1:0]   trig_i,
  input  logic [2*CHANNELS-1:0] mode_i,
  input  logic [CNT_WIDTH-1:0]  pulse_len,
  output logic [CHANNELS-1:0]   pulse_o,
  output logic                  busy_o
);

  logic [CHANNELS-1:0] busy_w;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    arcade_trigger_chan #(
      .CNT_WIDTH (CNT_WIDTH),
      .SYNC_STG  (SYNC_STG)
    ) u_chan (
      .clk_sys   (clk_sys),
      .reset_n   (reset_n),
      .ce        (ce),
      .trig_i    (trig_i[g]),
      .mode_i    (trig_mode_t'(mode_i[2*g +: 2])),
      .pulse_len (pulse_len),
      .pulse_o   (pulse_o[g]),
      .busy_o    (busy_w[g])
    );
  end

  assign busy_o = |busy_w;

endmodule

// File: tb/tb_arcade_trigger_gen.sv
// Self-checking bench for arcade_trigger_gen.
// Directed scenarios plus random stimulus vs a tick model.
module tb_arcade_trigger_gen;

  localparam int CH = 4;
  localparam int CW = 20;
  localparam int SS = 2;

  logic            clk_sys = 1'b0;
  logic            reset_n = 1'b0;
  logic            ce = 1'b0;
  logic [CH-1:0]   trig_i = '0;
  logic [2*CH-1:0] mode_i = '0;
  logic [CW-1:0]   pulse_len = '0;
  logic [CH-1:0]   pulse_o;
  logic            busy_o;

  int errors = 0;
  int checks = 0;

  // model: per-channel ce-tick sample history, arming,
  // phase (0 idle, 1 high, 2 gap) and ticks left in it
  bit         hist[CH][8];
  bit         armed[CH];
  int         ticks;
  int         ph[CH];
  int         left[CH];
  logic [1:0] mprev[CH];
  logic [CH-1:0] exp_p;
  logic       exp_b;

  int trk;
  int hi_cnt;
  int bursts;
  bit last_hi;
  int first;

  arcade_trigger_gen #(
    .CHANNELS  (CH),
    .CNT_WIDTH (CW),
    .SYNC_STG  (SS)
  ) dut (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .ce        (ce),
    .trig_i    (trig_i),
    .mode_i    (mode_i),
    .pulse_len (pulse_len),
    .pulse_o   (pulse_o),
    .busy_o    (busy_o)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      for (int i = 0; i < 8; i++) hist[c][i] = 1'b0;
      armed[c] = 1'b0;
      ph[c]    = 0;
      left[c]  = 0;
      mprev[c] = 2'b00;
    end
    ticks = 0;
    exp_p = '0;
    exp_b = 1'b0;
  endtask

  task automatic model_tick();
    for (int c = 0; c < CH; c++) begin
      bit s;
      bit sp;
      bit rise;
      bit o;
      logic [1:0] m;
      int len;
      s    = hist[c][SS-1];
      sp   = hist[c][SS];
      rise = s && !sp && armed[c];
      if (ticks >= SS && !s) armed[c] = 1'b1;
      m   = mode_i[2*c +: 2];
      len = int'(pulse_len);
      o   = 1'b0;
      if (m != mprev[c]) begin
        ph[c]    = 0;
        mprev[c] = m;
      end else if (m == 2'b00) begin
        ph[c] = 0;
      end else if (m == 2'b10) begin
        ph[c] = 0;
        o     = s;
      end else if (m == 2'b01) begin
        if (rise && len > 0) begin
          ph[c]   = 1;
          left[c] = len;
        end else if (ph[c] != 0 && left[c] == 0) begin
          ph[c] = 0;
        end
        o = (ph[c] == 1);
        if (ph[c] != 0) left[c]--;
      end else begin
        if (ph[c] == 0) begin
          if (rise && len > 0) begin
            ph[c]   = 1;
            left[c] = len;
          end
        end else if (left[c] == 0) begin
          if (ph[c] == 1 && len > 0) begin
            ph[c]   = 2;
            left[c] = len;
          end else if (ph[c] == 2 && s && len > 0) begin
            ph[c]   = 1;
            left[c] = len;
          end else begin
            ph[c] = 0;
          end
        end
        o = (ph[c] == 1);
        if (ph[c] != 0) left[c]--;
      end
      exp_p[c] = o;
      for (int i = 7; i > 0; i--) hist[c][i] = hist[c][i-1];
      hist[c][0] = trig_i[c];
    end
    ticks++;
    exp_b = 1'b0;
    for (int c = 0; c < CH; c++) if (ph[c] != 0) exp_b = 1'b1;
  endtask

  task automatic chk(string tag);
    checks++;
    assert (pulse_o === exp_p) else begin
      errors++;
      $error("FAIL %s pulse_o=%h expected %h", tag, pulse_o, exp_p);
    end
    checks++;
    assert (busy_o === exp_b) else begin
      errors++;
      $error("FAIL %s busy_o=%b expected %b", tag, busy_o, exp_b);
    end
  endtask

  task automatic expect_int(string tag, int got, int want);
    checks++;
    assert (got == want) else begin
      errors++;
      $error("FAIL %s got=%0d expected %0d", tag, got, want);
    end
  endtask

  task automatic step(string tag);
    @(posedge clk_sys);
    if (reset_n && ce) model_tick();
    @(negedge clk_sys);
    chk(tag);
    if (pulse_o[trk]) begin
      hi_cnt++;
      if (!last_hi) bursts++;
    end
    last_hi = pulse_o[trk];
  endtask

  task automatic clr_trk(int ch);
    trk     = ch;
    hi_cnt  = 0;
    bursts  = 0;
    last_hi = pulse_o[ch];
  endtask

  initial begin
    model_reset();
    trk = 0;

    // reset with all triggers high, then held after release
    trig_i    = '1;
    mode_i    = 8'h55;
    pulse_len = CW'(5);
    ce        = 1'b1;
    reset_n   = 1'b0;
    #1 chk("reset");
    repeat (3) step("reset_hold");
    reset_n = 1'b1;
    clr_trk(0);
    repeat (10) step("held_after_reset");
    expect_int("held_no_pulse", hi_cnt, 0);

    // oneshot, length 5, latency 3 edges
    trig_i = '0;
    mode_i = 8'h01;
    repeat (6) step("oneshot_pre");
    clr_trk(0);
    first = -1;
    trig_i[0] = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      step("oneshot");
      if (pulse_o[0] && first < 0) first = i;
    end
    expect_int("oneshot_latency", first, 3);
    expect_int("oneshot_width", hi_cnt, 5);
    expect_int("oneshot_bursts", bursts, 1);

    // retrigger at pulse tick 6 with length 10
    trig_i    = '0;
    pulse_len = CW'(10);
    repeat (4) step("retrig_pre");
    clr_trk(0);
    trig_i[0] = 1'b1;
    repeat (2) step("retrig");
    trig_i[0] = 1'b0;
    repeat (3) step("retrig");
    trig_i[0] = 1'b1;
    repeat (2) step("retrig");
    trig_i[0] = 1'b0;
    repeat (20) step("retrig");
    expect_int("retrig_width", hi_cnt, 15);
    expect_int("retrig_no_gap", bursts, 1);

    // repeat on ch1, length 3, held 20 ticks
    trig_i    = '0;
    mode_i    = 8'h0C;
    pulse_len = CW'(3);
    repeat (4) step("repeat_pre");
    clr_trk(1);
    trig_i[1] = 1'b1;
    repeat (20) step("repeat");
    trig_i[1] = 1'b0;
    repeat (12) step("repeat_tail");
    expect_int("repeat_high", hi_cnt, 12);
    expect_int("repeat_bursts", bursts, 4);
    expect_int("repeat_idle", int'(busy_o), 0);

    // ce toggling stretches a 4-tick pulse to 8 clocks
    mode_i    = 8'h01;
    pulse_len = CW'(4);
    repeat (3) step("ce_pre");
    clr_trk(0);
    trig_i[0] = 1'b1;
    for (int i = 0; i < 24; i++) begin
      ce = (i % 2 == 0);
      step("ce_gate");
    end
    expect_int("ce_width", hi_cnt, 8);
    expect_int("ce_bursts", bursts, 1);

    // mode change mid-pulse clears on next tick
    ce        = 1'b1;
    trig_i[0] = 1'b0;
    repeat (3) step("mchg_pre");
    trig_i[0] = 1'b1;
    repeat (4) step("mchg_pulse");
    expect_int("mchg_before", int'(pulse_o[0]), 1);
    mode_i = 8'h02;
    step("mchg");
    expect_int("mchg_cleared", int'(pulse_o[0]), 0);
    step("mchg_level");
    expect_int("mchg_level_on", int'(pulse_o[0]), 1);

    // zero length oneshot never pulses
    mode_i    = 8'h01;
    pulse_len = '0;
    trig_i    = '0;
    repeat (4) step("len0_pre");
    clr_trk(0);
    trig_i[0] = 1'b1;
    repeat (10) step("len0");
    expect_int("len0_no_pulse", hi_cnt, 0);

    // level mode follows input three edges later
    mode_i = 8'h20;
    trig_i = '0;
    repeat (4) step("level_pre");
    trig_i[2] = 1'b1;
    repeat (2) step("level");
    expect_int("level_not_yet", int'(pulse_o[2]), 0);
    step("level");
    expect_int("level_on", int'(pulse_o[2]), 1);
    trig_i[2] = 1'b0;
    repeat (3) step("level");
    expect_int("level_off", int'(pulse_o[2]), 0);

    // asynchronous reset in the middle of a repeat pulse
    mode_i    = 8'h0C;
    pulse_len = CW'(3);
    trig_i    = '0;
    repeat (4) step("rst_pre");
    trig_i[1] = 1'b1;
    repeat (4) step("rst_pulse");
    expect_int("rst_pulse_on", int'(pulse_o[1]), 1);
    @(posedge clk_sys);
    #2 reset_n = 1'b0;
    model_reset();
    #1 chk("async_reset");
    @(negedge clk_sys);
    reset_n = 1'b1;
    clr_trk(1);
    repeat (8) step("post_reset_held");
    expect_int("post_reset_no_pulse", hi_cnt, 0);

    // random traffic against the model
    mode_i    = 8'hD9;
    pulse_len = CW'(2);
    for (int i = 0; i < 400; i++) begin
      ce = ($urandom_range(0, 3) != 0);
      for (int c = 0; c < CH; c++)
        if ($urandom_range(0, 3) == 0) trig_i[c] = ~trig_i[c];
      if ($urandom_range(0, 19) == 0) mode_i = (2*CH)'($urandom);
      if ($urandom_range(0, 29) == 0) pulse_len = CW'($urandom_range(0, 5));
      step("random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
